// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, jump redirect, interrupt entry
// sequencing and a stall watchdog for the 5-stage RV32 core.
module pipe_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stallreq_if_i,
  input  logic                  stallreq_id_i,
  input  logic                  stallreq_exe_i,
  input  logic                  stallreq_mem_i,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  int_req_i,
  input  logic [ADDR_WIDTH-1:0] int_addr_i,
  output logic [5:0]            stall_o,
  output logic                  flush_jump_o,
  output logic                  flush_int_o,
  output logic                  pc_we_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  int_ack_o,
  output logic                  stall_timeout_o
);

  localparam int CW = $clog2(STALL_TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            timeout_q;
  logic [5:0]      stall_req;

  // Highest requesting stage wins; it and everything upstream stop.
  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem_i)      stall_req = 6'b011111;
    else if (stallreq_exe_i) stall_req = 6'b001111;
    else if (stallreq_id_i)  stall_req = 6'b000111;
    else if (stallreq_if_i)  stall_req = 6'b000011;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (int_req_i) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!int_req_i)
          state_nxt = IDLE;
        else if (!stallreq_mem_i && !stallreq_exe_i && !jump_i)
          state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_o      = 6'b000000;
    flush_jump_o = 1'b0;
    flush_int_o  = 1'b0;
    pc_we_o      = 1'b0;
    pc_o         = '0;
    int_ack_o    = 1'b0;
    if (!rst_i) begin
      if (state == FLUSH) begin
        flush_int_o = 1'b1;
        pc_we_o     = 1'b1;
        pc_o        = int_addr_i;
        int_ack_o   = 1'b1;
      end else begin
        stall_o = stall_req;
        if (state == DRAIN) stall_o[1:0] = 2'b11;
        if (jump_i && !stallreq_mem_i) begin
          flush_jump_o = 1'b1;
          pc_we_o      = 1'b1;
          pc_o         = jump_addr_i;
        end
      end
    end
  end

  always_comb begin
    cnt_nxt = '0;
    if (stall_o[0])
      cnt_nxt = (cnt == LIMIT) ? cnt : cnt + CW'(1);
  end

  assign stall_timeout_o = timeout_q & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      timeout_q <= timeout_q | (cnt_nxt == LIMIT);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (STALL_TIMEOUT = 8).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_if, s_id, s_exe, s_mem;
  logic        jump;
  logic [31:0] jump_addr;
  logic        int_req;
  logic [31:0] int_addr;
  logic [5:0]  stall;
  logic        flush_jump, flush_int, pc_we, int_ack, timeout;
  logic [31:0] pc;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.ADDR_WIDTH(32), .STALL_TIMEOUT(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stallreq_if_i   (s_if),
    .stallreq_id_i   (s_id),
    .stallreq_exe_i  (s_exe),
    .stallreq_mem_i  (s_mem),
    .jump_i          (jump),
    .jump_addr_i     (jump_addr),
    .int_req_i       (int_req),
    .int_addr_i      (int_addr),
    .stall_o         (stall),
    .flush_jump_o    (flush_jump),
    .flush_int_o     (flush_int),
    .pc_we_o         (pc_we),
    .pc_o            (pc),
    .int_ack_o       (int_ack),
    .stall_timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_if = 0; s_id = 0; s_exe = 0; s_mem = 1;
    jump = 1; jump_addr = 32'h1234_5678;
    int_req = 0; int_addr = 32'h0000_0100;
    tick();
    tick();
    checks++;
    if (stall !== 6'b0) begin
      errors++;
      $display("FAIL reset_stall got=%b exp=%b", stall, 6'b0);
    end
    checks++;
    if ({flush_jump, pc_we, pc, int_ack, timeout} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outs fj=%b we=%b pc=%h ack=%b to=%b exp all 0",
               flush_jump, pc_we, pc, int_ack, timeout);
    end
    s_mem = 0; jump = 0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    s_id = 1;
    #1;
    checks++;
    if (stall !== 6'b000111) begin
      errors++;
      $display("FAIL prio_id got=%b exp=%b", stall, 6'b000111);
    end
    s_mem = 1;
    #1;
    checks++;
    if (stall !== 6'b011111) begin
      errors++;
      $display("FAIL prio_mem_id got=%b exp=%b", stall, 6'b011111);
    end
    s_mem = 0; s_id = 0; s_exe = 1;
    #1;
    checks++;
    if (stall !== 6'b001111) begin
      errors++;
      $display("FAIL prio_exe got=%b exp=%b", stall, 6'b001111);
    end
    s_exe = 0; s_if = 1;
    #1;
    checks++;
    if (stall !== 6'b000011) begin
      errors++;
      $display("FAIL prio_if got=%b exp=%b", stall, 6'b000011);
    end
    s_if = 0;
    #1;
    checks++;
    if (stall !== 6'b000000) begin
      errors++;
      $display("FAIL prio_none got=%b exp=%b", stall, 6'b000000);
    end
    tick();
  endtask

  task automatic test_jump();
    jump = 1; jump_addr = 32'h8000_0040;
    #1;
    checks++;
    if ({flush_jump, pc_we, pc} !== {2'b11, 32'h8000_0040}) begin
      errors++;
      $display("FAIL jump_take fj=%b we=%b pc=%h exp 1 1 80000040",
               flush_jump, pc_we, pc);
    end
    s_mem = 1;
    #1;
    checks++;
    if ({flush_jump, pc_we, pc} !== 34'h0) begin
      errors++;
      $display("FAIL jump_held fj=%b we=%b pc=%h exp 0 0 0",
               flush_jump, pc_we, pc);
    end
    s_mem = 0; jump = 0;
    tick();
  endtask

  task automatic test_drain();
    int_req = 1; int_addr = 32'h0000_0100; s_exe = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (stall !== 6'b001111 || int_ack !== 1'b0 || flush_int !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold%0d stall=%b ack=%b fi=%b exp 001111 0 0",
                 i, stall, int_ack, flush_int);
      end
    end
    tick();
    s_exe = 0;
    #1;
    checks++;
    if (stall !== 6'b000011 || int_ack !== 1'b0) begin
      errors++;
      $display("FAIL drain_release stall=%b ack=%b exp 000011 0",
               stall, int_ack);
    end
    tick();
    checks++;
    if ({flush_int, int_ack, pc_we, pc, stall} !== {3'b111, 32'h100, 6'b0}) begin
      errors++;
      $display("FAIL drain_flush fi=%b ack=%b we=%b pc=%h stall=%b exp 1 1 1 100 0",
               flush_int, int_ack, pc_we, pc, stall);
    end
    int_req = 0;
    tick();
    checks++;
    if (int_ack !== 1'b0 || flush_int !== 1'b0 || stall !== 6'b0) begin
      errors++;
      $display("FAIL drain_after ack=%b fi=%b stall=%b exp 0 0 0",
               int_ack, flush_int, stall);
    end
  endtask

  task automatic test_int_vs_jump();
    int_req = 1; int_addr = 32'h0000_0200;
    tick();
    checks++;
    if (stall !== 6'b000011) begin
      errors++;
      $display("FAIL ivj_drain stall=%b exp=%b", stall, 6'b000011);
    end
    tick();
    jump = 1; jump_addr = 32'h8000_0040;
    #1;
    checks++;
    if ({pc, flush_jump, int_ack, flush_int} !== {32'h200, 3'b011}) begin
      errors++;
      $display("FAIL ivj_flush pc=%h fj=%b ack=%b fi=%b exp 200 0 1 1",
               pc, flush_jump, int_ack, flush_int);
    end
    int_req = 0; jump = 0;
    tick();
    checks++;
    if (int_ack !== 1'b0) begin
      errors++;
      $display("FAIL ivj_ack_once ack=%b exp=0", int_ack);
    end
  endtask

  task automatic test_withdraw();
    int_req = 1; s_mem = 1;
    tick();
    int_req = 0; s_mem = 0;
    #1;
    checks++;
    if (stall !== 6'b000011 || int_ack !== 1'b0) begin
      errors++;
      $display("FAIL wd_drain stall=%b ack=%b exp 000011 0", stall, int_ack);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (stall !== 6'b0 || int_ack !== 1'b0 || flush_int !== 1'b0) begin
        errors++;
        $display("FAIL wd_idle%0d stall=%b ack=%b fi=%b exp 0 0 0",
                 i, stall, int_ack, flush_int);
      end
    end
  endtask

  task automatic test_watchdog();
    s_mem = 1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL wdog_7 got=%b exp=0", timeout);
    end
    s_mem = 0;
    tick();
    s_mem = 1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL wdog_7b got=%b exp=0", timeout);
    end
    tick();
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL wdog_8 got=%b exp=1", timeout);
    end
    s_mem = 0;
    tick();
    tick();
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL wdog_sticky got=%b exp=1", timeout);
    end
  endtask

  task automatic test_async_reset();
    int_req = 1; s_mem = 1;
    tick();
    checks++;
    if (stall !== 6'b011111) begin
      errors++;
      $display("FAIL ar_drain stall=%b exp=%b", stall, 6'b011111);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if ({stall, int_ack, flush_int, pc_we, timeout} !== 10'b0) begin
      errors++;
      $display("FAIL ar_async stall=%b ack=%b fi=%b we=%b to=%b exp all 0",
               stall, int_ack, flush_int, pc_we, timeout);
    end
    int_req = 0; s_mem = 0;
    tick();
    rst = 0;
    tick();
    checks++;
    if (stall !== 6'b0 || int_ack !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL ar_idle stall=%b ack=%b to=%b exp 0 0 0",
               stall, int_ack, timeout);
    end
    s_mem = 1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL ar_cnt_clr got=%b exp=0", timeout);
    end
    tick();
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL ar_cnt_8 got=%b exp=1", timeout);
    end
    s_mem = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_jump();
    test_drain();
    test_int_vs_jump();
    test_withdraw();
    test_watchdog();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 5-stage RV32 core: merges per-stage stall requests, branch/jump redirects and interrupt entry into the `stall_o[5:0]`, `flush_jump_o` and `flush_int_o` controls consumed by every pipeline register (if_id, id_exe, exe_mem, mem_wb) and the PC register. The stall and jump paths are combinational. Interrupt entry is sequenced by a small FSM that drains in-flight bus and multi-cycle operations before flushing. A stall watchdog flags a hung pipeline.

## Interface
- `ADDR_WIDTH`, 32: PC / jump / trap address width.
- `STALL_TIMEOUT`, 1024: consecutive stalled cycles that set `stall_timeout_o`. Minimum value is 2.
- `clk_i` in 1: the single clock. All state is updated on its rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `stallreq_if_i` in 1: instruction bus wait.
- `stallreq_id_i` in 1: load-use hazard.
- `stallreq_exe_i` in 1: multi-cycle ALU (div) busy.
- `stallreq_mem_i` in 1: data bus wait.
- `jump_i` in 1: exe resolves a taken branch or jump.
- `jump_addr_i` in ADDR_WIDTH: jump target.
- `int_req_i` in 1: interrupt/exception request, level. Held until `int_ack_o`.
- `int_addr_i` in ADDR_WIDTH: trap vector.
- `stall_o` out 6: bit0 pc, bit1 if_id, bit2 id_exe, bit3 exe_mem, bit4 mem_wb, bit5 reserved (always 0). 1 = `STOP`.
- `flush_jump_o` out 1: flush if_id/id_exe for a jump.
- `flush_int_o` out 1: flush all pipeline registers for trap entry.
- `pc_we_o` out 1: load `pc_o` into the PC register this edge.
- `pc_o` out ADDR_WIDTH: redirect target.
- `int_ack_o` out 1: one-cycle pulse, trap taken.
- `stall_timeout_o` out 1: sticky watchdog flag.

## Operation
- Stall encoding: a request from stage k sets `stall_o[k:0]` and clears all higher bits, so stage k+1 receives a bubble. This is the STOP/NOSTOP rule every pipeline register already uses.
- Stage mapping: if→k=1, id→k=2, exe→k=3, mem→k=4.
- Priority: when several requests are active, the highest k wins. Examples: mem+id gives `6'b011111`; only if gives `6'b000011`.
- Jump acceptance: a jump is accepted when `jump_i=1`, `stallreq_mem_i=0` and `state!=FLUSH`.
  - On acceptance: `flush_jump_o=1`, `pc_we_o=1`, `pc_o=jump_addr_i`.
  - While `stallreq_mem_i=1`, the jump is held by the exe stall and `flush_jump_o=0`.
- FSM states: IDLE, DRAIN, FLUSH.
  - IDLE → DRAIN when `int_req_i=1`.
  - DRAIN: forces `stall_o[1:0]=2'b11` (OR with the normal vector) so no new instruction enters.
  - DRAIN → FLUSH when `stallreq_mem_i=0`, `stallreq_exe_i=0` and `jump_i=0`.
  - DRAIN → IDLE if `int_req_i` drops (request withdrawn, no ack).
  - A jump accepted during DRAIN is serviced normally and the FSM stays in DRAIN.
  - FLUSH lasts exactly one cycle, then → IDLE.
- FLUSH outputs: `flush_int_o=1`, `pc_we_o=1`, `pc_o=int_addr_i`, `int_ack_o=1`, `stall_o=0`, `flush_jump_o=0`. Interrupt beats any concurrent `jump_i`.
- Watchdog: a counter of width clog2(STALL_TIMEOUT)+1.
  - Increments each cycle `stall_o[0]=1`.
  - Clears to 0 when `stall_o[0]=0`.
  - Saturates at STALL_TIMEOUT.
  - When it reaches STALL_TIMEOUT, `stall_timeout_o` is set. Only reset clears it.
- When no redirect is active: `pc_o=0` and `pc_we_o=0`.

## Timing
- Combinational (same cycle as inputs): `stall_o`, `flush_jump_o`, `pc_we_o`, `pc_o`. Pipeline registers act on them at the next rising edge.
- Decoded from registered state: `flush_int_o`, `int_ack_o`, DRAIN forcing.
- Interrupt latency: `int_req_i` at cycle 0 with no stalls gives DRAIN at cycle 1 and FLUSH/ack at cycle 2. Each cycle of pending mem/exe stall or jump adds one cycle.
- Reset behaviour:
  - While `rst_i=1`: state=IDLE, counter=0, `stall_timeout_o=0`, and all outputs are forced to 0.
  - Reset asserted mid-DRAIN or mid-FLUSH aborts the sequence with no ack.
- `int_ack_o` is never asserted in two consecutive cycles. The requester must drop `int_req_i` within one cycle of ack; otherwise the request re-enters DRAIN.

## Test plan
- Priority: `stallreq_id_i=1` gives `stall_o=6'b000111`. Adding `stallreq_mem_i=1` gives `6'b011111`. Only `stallreq_if_i` gives `6'b000011`.
- Jump: `jump_i=1`, `jump_addr_i=32'h8000_0040`, no stalls → `flush_jump_o=1`, `pc_we_o=1`, `pc_o=32'h8000_0040` in the same cycle. Repeat with `stallreq_mem_i=1` → `flush_jump_o=0` and `pc_we_o=0`.
- Interrupt drain:
  - Stimulus: `int_req_i=1`, `int_addr_i=32'h0000_0100`, `stallreq_exe_i=1` held for 3 cycles.
  - Required: `stall_o[1:0]=11` throughout DRAIN.
  - Required: FLUSH one cycle after exe releases, with `flush_int_o=1`, `int_ack_o=1`, `pc_o=32'h100`.
- Interrupt vs jump: `jump_i=1` in the FLUSH cycle → `pc_o=int_addr_i` and `flush_jump_o=0`. Withdraw `int_req_i` during DRAIN → return to IDLE with no `int_ack_o`.
- Watchdog: with STALL_TIMEOUT=8, hold `stallreq_mem_i=1` for 8 cycles → `stall_timeout_o=1` after the 8th edge, and it stays 1 after the stall is removed. A 7-cycle stall leaves it 0.
- Async reset: assert `rst_i` mid-DRAIN between clock edges → outputs go to 0 immediately, with no ack. After release, state is IDLE and the counter is 0.
